// File: rtl/ysyx_23060184_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids, width defaults.
package ysyx_23060184_mem_arbiter_pkg;

  localparam int ARB_ADDR_WIDTH = 32;
  localparam int ARB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // The same encoding is used for the owner register and the tie-break pointer.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_23060184_arb_pick.sv
// Two-way winner selection: a lone requester always wins, a tie goes to the master named by ptr.
module ysyx_23060184_arb_pick
  import ysyx_23060184_mem_arbiter_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic ptr,
  output logic grant_ifu,
  output logic grant_lsu
);

  always_comb begin
    grant_lsu = lsu_valid && (!ifu_valid || ptr == OWN_LSU);
    grant_ifu = ifu_valid && !grant_lsu;
  end

endmodule

// File: rtl/ysyx_23060184_mem_arbiter.sv
// Shares one memory port between IFU and LSU with a single outstanding request (IDLE -> ISSUE -> WAIT).
// Define ARB_RR_EN for round-robin tie-break; otherwise LSU always wins ties.
module ysyx_23060184_mem_arbiter
  import ysyx_23060184_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,

  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,

  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  arb_state_t              state;
  owner_t                  owner;
  logic                    ptr;
  logic                    issue_q;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_wen;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wmask;

  logic grant_ifu;
  logic grant_lsu;
  logic in_idle;
  logic in_wait;

  // Without ARB_RR_EN the pointer never leaves its reset value (LSU), which is fixed priority.
  ysyx_23060184_arb_pick u_pick (
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .ptr       (ptr),
    .grant_ifu (grant_ifu),
    .grant_lsu (grant_lsu)
  );

  assign in_idle = (state == ST_IDLE);
  assign in_wait = (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      owner     <= OWN_IFU;
      ptr       <= OWN_LSU;
      issue_q   <= 1'b0;
      req_addr  <= '0;
      req_wen   <= 1'b0;
      req_wdata <= '0;
      req_wmask <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_lsu) begin
            state     <= ST_ISSUE;
            owner     <= OWN_LSU;
            issue_q   <= 1'b1;
            req_addr  <= lsu_addr;
            req_wen   <= lsu_wen;
            req_wdata <= lsu_wdata;
            req_wmask <= lsu_wmask;
          end else if (grant_ifu) begin
            // Fetches are always reads: clear the write fields so no stale store leaks out.
            state     <= ST_ISSUE;
            owner     <= OWN_IFU;
            issue_q   <= 1'b1;
            req_addr  <= ifu_addr;
            req_wen   <= 1'b0;
            req_wdata <= '0;
            req_wmask <= '0;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            state   <= ST_WAIT;
            issue_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            state <= ST_IDLE;
`ifdef ARB_RR_EN
            ptr   <= ~ptr;
`endif
          end
        end
        default: begin
          state   <= ST_IDLE;
          issue_q <= 1'b0;
        end
      endcase
    end
  end

  // Handshake outputs are gated by rstn so nothing is offered or accepted while reset is held.
  assign ifu_req_ready  = rstn && in_idle && grant_ifu;
  assign lsu_req_ready  = rstn && in_idle && grant_lsu;
  assign mem_req_valid  = rstn && issue_q;
  assign ifu_resp_valid = rstn && in_wait && mem_resp_valid && (owner == OWN_IFU);
  assign lsu_resp_valid = rstn && in_wait && mem_resp_valid && (owner == OWN_LSU);

  assign mem_addr  = req_addr;
  assign mem_wen   = req_wen;
  assign mem_wdata = req_wdata;
  assign mem_wmask = req_wmask;

  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// Directed bench: queue-driven masters, a latency-programmable memory, and a transaction-level model checked every cycle.
module tb_ysyx_23060184_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  ysyx_23060184_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  req_t ifu_q[$];
  req_t lsu_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit   m_busy = 0, m_issued = 0, m_own = 0, m_ptr = 1;
  req_t m_req;
  int   cyc = 0;
  int   grant_log[$];
  int   grant_cyc[$];
  req_t hs_log[$];
  int   hs_cyc[$];
  int   ifu_resp_cnt = 0, lsu_resp_cnt = 0;
  int   last_ifu_resp_cyc = 0, last_lsu_resp_cyc = 0, first_mreq_cyc = -1;
  logic [31:0] last_ifu_rdata = '0;

  initial begin
    bit lsu_win, ifu_win, resp_now;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        chk("reset_outputs", {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid}, '0);
        m_busy = 0; m_issued = 0; m_ptr = 1;
      end else begin
        lsu_win  = !m_busy && lsu_req_valid && (!ifu_req_valid || m_ptr);
        ifu_win  = !m_busy && ifu_req_valid && !lsu_win;
        resp_now = m_busy && m_issued && mem_resp_valid;
        chk("ifu_req_ready", ifu_req_ready, ifu_win);
        chk("lsu_req_ready", lsu_req_ready, lsu_win);
        chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
        if (m_busy && !m_issued)
          chk("mem_payload", {mem_addr, mem_wen, mem_wdata, mem_wmask}, m_req);
        chk("ifu_resp_valid", ifu_resp_valid, resp_now && !m_own);
        chk("lsu_resp_valid", lsu_resp_valid, resp_now && m_own);
        chk("rdata_mirror", {ifu_rdata, lsu_rdata}, {mem_rdata, mem_rdata});
        if (ifu_resp_valid) begin ifu_resp_cnt++; last_ifu_rdata = ifu_rdata; last_ifu_resp_cyc = cyc; end
        if (lsu_resp_valid) begin lsu_resp_cnt++; last_lsu_resp_cyc = cyc; end
        if (mem_req_valid && first_mreq_cyc < 0) first_mreq_cyc = cyc;

        if (lsu_win || ifu_win) begin
          m_busy = 1; m_issued = 0; m_own = lsu_win;
          if (lsu_win) begin
            m_req.addr = lsu_addr; m_req.wen = lsu_wen; m_req.wdata = lsu_wdata; m_req.wmask = lsu_wmask;
          end else begin
            m_req.addr = ifu_addr; m_req.wen = 1'b0; m_req.wdata = '0; m_req.wmask = '0;
          end
          grant_log.push_back(int'(lsu_win));
          grant_cyc.push_back(cyc);
        end else if (m_busy && !m_issued && mem_req_ready) begin
          m_issued = 1;
          hs_log.push_back({mem_addr, mem_wen, mem_wdata, mem_wmask});
          hs_cyc.push_back(cyc);
        end else if (resp_now) begin
          m_busy = 0;
`ifdef ARB_RR_EN
          m_ptr = !m_ptr;
`endif
        end
      end
    end
  end

  // ---------------- masters: hold valid until accepted, scramble payload when idle ----------------
  initial begin
    bit acc;
    ifu_req_valid = 0; ifu_addr = '0;
    forever begin
      @(negedge clk);
      acc = ifu_req_valid && ifu_req_ready;
      @(posedge clk); #1;
      if (acc) void'(ifu_q.pop_front());
      if (ifu_q.size() > 0) begin
        ifu_req_valid = 1; ifu_addr = ifu_q[0].addr;
      end else begin
        ifu_req_valid = 0; ifu_addr = $urandom;
      end
    end
  end

  initial begin
    bit acc;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    forever begin
      @(negedge clk);
      acc = lsu_req_valid && lsu_req_ready;
      @(posedge clk); #1;
      if (acc) void'(lsu_q.pop_front());
      if (lsu_q.size() > 0) begin
        lsu_req_valid = 1; lsu_addr = lsu_q[0].addr; lsu_wen = lsu_q[0].wen;
        lsu_wdata = lsu_q[0].wdata; lsu_wmask = lsu_q[0].wmask;
      end else begin
        lsu_req_valid = 0; lsu_addr = $urandom; lsu_wen = 1'($urandom);
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      end
    end
  end

  // ---------------- memory: stall_cfg cycles before ready, lat_cfg idle WAIT cycles before response ----------------
  int stall_cfg = 0, lat_cfg = 0, stall_cnt = 0, wait_cnt = 0;
  int stale_req = 0, stale_done = 0;
  bit inflight = 0;
  logic [31:0] bfm_addr = '0;

  function automatic logic [31:0] resp_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_0000);
  endfunction

  initial begin
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = $urandom;
      if (!rstn) begin
        inflight = 0; stall_cnt = stall_cfg;
      end else if (stale_req != stale_done) begin
        mem_resp_valid = 1; mem_rdata = 32'hBAD0_BAD0; stale_done++;
      end else if (inflight) begin
        if (wait_cnt == 0) begin
          mem_resp_valid = 1; mem_rdata = resp_data(bfm_addr); inflight = 0; stall_cnt = stall_cfg;
        end else wait_cnt--;
      end else if (mem_req_valid) begin
        if (stall_cnt <= 0) begin
          mem_req_ready = 1; inflight = 1; wait_cnt = lat_cfg; bfm_addr = mem_addr;
        end else stall_cnt--;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset(input int stall, input int lat);
    stall_cfg = stall; lat_cfg = lat;
    rstn = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    grant_log.delete(); grant_cyc.delete(); hs_log.delete(); hs_cyc.delete();
    ifu_resp_cnt = 0; lsu_resp_cnt = 0; first_mreq_cyc = -1;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    @(negedge clk);
    while ((ifu_q.size() != 0 || lsu_q.size() != 0 || m_busy || ifu_req_valid || lsu_req_valid) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, n);
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    req_t r;
    r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
    return r;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    logic [3:0] order;
    int n;

    // Reset values of the latched payload
    do_reset(0, 1);
    chk("reset_payload", {mem_addr, mem_wen, mem_wdata, mem_wmask}, '0);

    // Lone IFU fetch: mem_req_valid one cycle after accept, response two cycles after that
    ifu_q.push_back(mk(32'h8000_0000, 0, 0, 0));
    wait_idle("fetch", 50);
    chk("fetch_grants", grant_log.size(), 1);
    chk("fetch_owner", grant_log[0], 0);
    chk("fetch_mreq_lat", first_mreq_cyc - grant_cyc[0], 1);
    chk("fetch_resp_lat", last_ifu_resp_cyc - grant_cyc[0], 3);
    chk("fetch_resp_cnt", ifu_resp_cnt, 1);
    chk("fetch_rdata", last_ifu_rdata, 32'h0000_0413);
    chk("fetch_lsu_quiet", lsu_resp_cnt, 0);

    // Simultaneous requests: LSU store first, IFU granted the cycle after the LSU response
    do_reset(0, 0);
    lsu_q.push_back(mk(32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF));
    ifu_q.push_back(mk(32'h8000_0004, 0, 0, 0));
    wait_idle("tie", 50);
    chk("tie_order", {grant_log[0], grant_log[1]}, {32'd1, 32'd0});
    chk("tie_store_payload", hs_log[0], mk(32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF));
    chk("tie_fetch_payload", hs_log[1], mk(32'h8000_0004, 0, 0, 0));
    chk("tie_regrant_gap", grant_cyc[1] - last_lsu_resp_cyc, 1);

    // Memory stalls 3 cycles while the LSU scrambles its inputs
    do_reset(3, 0);
    lsu_q.push_back(mk(32'h8000_2000, 1, 32'h1234_5678, 4'h3));
    wait_idle("stall", 50);
    chk("stall_hs_payload", hs_log[0], mk(32'h8000_2000, 1, 32'h1234_5678, 4'h3));
    chk("stall_hs_cycle", hs_cyc[0] - grant_cyc[0], 4);
    chk("stall_resp_cnt", lsu_resp_cnt, 1);

    // Both masters continuously valid: tie-break policy over the first four grants
    do_reset(0, 0);
    for (int i = 0; i < 4; i++) begin
      ifu_q.push_back(mk(32'h8000_0100 + 32'(i * 4), 0, 0, 0));
      lsu_q.push_back(mk(32'h8000_3000 + 32'(i * 4), i[0], 32'hC0DE_0000 + 32'(i), 4'hF));
    end
    wait_idle("stream", 300);
    chk("stream_total", grant_log.size(), 8);
    order = {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]};
`ifdef ARB_RR_EN
    chk("stream_order", order, 4'b1010);
`else
    chk("stream_order", order, 4'b1111);
`endif

    // Reset while waiting for the response, then a stale response in IDLE
    do_reset(0, 6);
    ifu_q.push_back(mk(32'h8000_0010, 0, 0, 0));
    n = 0;
    while (!(m_busy && m_issued) && n < 30) begin @(negedge clk); n++; end
    chk("midreset_reached_wait", m_busy && m_issued, 1'b1);
    do_reset(0, 0);
    stale_req++;
    repeat (4) @(negedge clk);
    chk("stale_no_resp", {ifu_resp_cnt[7:0], lsu_resp_cnt[7:0]}, 16'h0);
    chk("stale_no_grant", grant_log.size(), 0);
    ifu_q.push_back(mk(32'h8000_0020, 0, 0, 0));
    wait_idle("post_reset", 50);
    chk("post_reset_grants", grant_log.size(), 1);
    chk("post_reset_resp", ifu_resp_cnt, 1);
    chk("post_reset_rdata", last_ifu_rdata, 32'h8000_0020 ^ 32'hA5A5_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/ysyx_23060184_mem_arbiter.md
YSYX_23060184_MEM_ARBITER -- requirements
Module: ysyx_23060184_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bit width of all address ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bit width of all data ports; mask width is DATA_WIDTH/8.
REQ-003 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port ifu_req_valid  in  1  IFU fetch request.
REQ-006 SHALL have port ifu_req_ready  out  1  IFU request accepted this cycle.
REQ-007 SHALL have port ifu_addr  in  ADDR_WIDTH  fetch address.
REQ-008 SHALL have port ifu_resp_valid  out  1  one-cycle IFU response pulse.
REQ-009 SHALL have port ifu_rdata  out  DATA_WIDTH  fetched instruction.
REQ-010 SHALL have port lsu_req_valid  in  1  LSU load/store request.
REQ-011 SHALL have port lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-012 SHALL have port lsu_addr  in  ADDR_WIDTH  load/store address.
REQ-013 SHALL have port lsu_wen  in  1  1 = store.
REQ-014 SHALL have port lsu_wdata  in  DATA_WIDTH  store data.
REQ-015 SHALL have port lsu_wmask  in  DATA_WIDTH/8  store byte enables.
REQ-016 SHALL have port lsu_resp_valid  out  1  one-cycle LSU response pulse.
REQ-017 SHALL have port lsu_rdata  out  DATA_WIDTH  load data.
REQ-018 SHALL have ports mem_req_valid out 1, mem_req_ready in 1: shared memory request handshake.
REQ-019 SHALL have ports mem_addr out ADDR_WIDTH, mem_wen out 1, mem_wdata out DATA_WIDTH, mem_wmask out DATA_WIDTH/8: request payload.
REQ-020 SHALL have ports mem_resp_valid in 1, mem_rdata in DATA_WIDTH: memory response.

Function
REQ-021 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE with a registered owner (IFU/LSU).
REQ-022 IDLE: SHALL pick a winner among valid requesters, assert that master's req_ready combinationally, latch its payload and owner, go ISSUE next cycle.
REQ-023 ISSUE: SHALL hold mem_req_valid=1 with latched payload, stable until mem_req_ready=1, then go WAIT.
REQ-024 WAIT: on mem_resp_valid=1 SHALL pulse owner's resp_valid same cycle (combinational) and return to IDLE; non-owner resp_valid stays 0.
REQ-025 ifu_rdata and lsu_rdata SHALL both equal mem_rdata at all times.
REQ-026 IFU grants SHALL drive mem_wen=0, mem_wmask=0, mem_wdata=0.
REQ-027 Minimum latency: accept at T, mem_req_valid at T+1, next grant no earlier than the cycle after the response.
REQ-028 req_ready SHALL be 0 outside IDLE; at most one master ready per cycle.
REQ-029 mem_resp_valid outside WAIT SHALL be ignored, no state change.
REQ-030 Master payload changes after acceptance SHALL NOT affect the in-flight request.

Reset
REQ-031 rstn=0 SHALL force IDLE, owner=IFU, priority pointer=LSU, latched payload 0, all valid/ready outputs 0, in any state; in-flight transaction dropped.

Configuration
REQ-032 Macro ARB_RR_EN defined: round-robin, pointer flips to the other master after each completed response, tie goes to pointer; undefined: fixed priority, LSU always wins ties.

Structure
REQ-033 Shared package SHALL hold FSM state encoding, owner encoding and width constants.
REQ-034 Winner selection SHALL be sub-module ysyx_23060184_arb_pick (valid bits + pointer in, grant out).

Verification
REQ-035 IFU only, addr 0x80000000, mem_req_ready=1, response 2 cycles later rdata 0x00000413 -> ifu_resp_valid one cycle, ifu_rdata 0x00000413, lsu_resp_valid 0.
REQ-036 Both valid in IDLE (LSU store 0x80001000, wdata 0xDEADBEEF, wmask 0xF) -> LSU granted first, mem_wen=1; IFU granted in the cycle after LSU response.
REQ-037 mem_req_ready low 3 cycles in ISSUE, master addr changed meanwhile -> mem_addr, mem_wdata stable at latched values.
REQ-038 ARB_RR_EN, both always valid, 4 transactions -> grants LSU, IFU, LSU, IFU; without macro -> LSU x4.
REQ-039 rstn=0 during WAIT, then stale mem_resp_valid in IDLE -> no resp_valid pulse, FSM stays IDLE.
